// File: rtl/gelato_l2_arbiter.sv
// Round-robin arbiter sharing one L2 slave port among NUM_L1 L1 requesters, one request in flight.
// Optional watchdog (sticky timeout_err) enabled by defining GELATO_L2_ARB_TIMEOUT_EN.
module gelato_l2_arbiter #(
  parameter int NUM_L1         = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_L1-1:0]              req_valid,
  input  logic [NUM_L1*ADDR_WIDTH-1:0]   req_addr,
  output logic [NUM_L1-1:0]              req_done,
  output logic [LINE_WIDTH-1:0]          req_data,
  output logic                           l2_valid,
  output logic [ADDR_WIDTH-1:0]          l2_addr,
  input  logic                           l2_done,
  input  logic [LINE_WIDTH-1:0]          l2_data,
  output logic                           busy,
  output logic [$clog2(NUM_L1)-1:0]      grant_id
`ifdef GELATO_L2_ARB_TIMEOUT_EN
  ,
  output logic                           timeout_err
`endif
);

  localparam int IDW = $clog2(NUM_L1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state_reg;
  logic [IDW-1:0]        grant_reg;
  logic [IDW-1:0]        rr_ptr_reg;
  logic [IDW-1:0]        pick_idx;
  logic [IDW-1:0]        grant_inc;
  logic                  pick_found;
  logic [NUM_L1-1:0]     done_onehot;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_L1];
  int                    scan_idx;

  generate
    for (genvar gi = 0; gi < NUM_L1; gi++) begin : g_req
      assign addr_arr[gi]    = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign done_onehot[gi] = (grant_reg == IDW'(gi));
    end
  endgenerate

  // Scan from the far end back toward rr_ptr so the closest valid requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int off = NUM_L1 - 1; off >= 0; off--) begin
      scan_idx = (int'(rr_ptr_reg) + off) % NUM_L1;
      if (req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(scan_idx);
      end
    end
  end

  assign grant_inc = (grant_reg == IDW'(NUM_L1 - 1)) ? '0 : grant_reg + IDW'(1);
  assign grant_id  = grant_reg;
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      l2_valid   <= 1'b0;
      l2_addr    <= '0;
      req_done   <= '0;
      req_data   <= '0;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg <= pick_idx;
            l2_addr   <= addr_arr[pick_idx];
            l2_valid  <= 1'b1;
            state_reg <= REQ;
          end
        end
        REQ: begin
          // Requester inputs are deliberately ignored until L2 answers.
          if (l2_done) begin
            req_data   <= l2_data;
            req_done   <= done_onehot;
            l2_valid   <= 1'b0;
            rr_ptr_reg <= grant_inc;
            state_reg  <= RESP;
          end
        end
        RESP: begin
          req_done  <= '0;
          state_reg <= IDLE;
        end
        default: begin
          l2_valid  <= 1'b0;
          req_done  <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef GELATO_L2_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt_reg;

  // Held at zero in IDLE, so every REQ entry starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg  <= '0;
      timeout_err <= 1'b0;
    end else if (state_reg == IDLE) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == REQ && !l2_done) begin
      if (wd_cnt_reg != CW'(TIMEOUT_CYCLES))
        wd_cnt_reg <= wd_cnt_reg + CW'(1);
      if (wd_cnt_reg >= CW'(TIMEOUT_CYCLES - 1))
        timeout_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gelato_l2_arbiter.sv
// Randomized and directed bench for gelato_l2_arbiter against a transaction-level reference model.
// Define GELATO_L2_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_gelato_l2_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 512;
  localparam int TO = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        req_valid;
  logic [N*AW-1:0]     req_addr;
  logic [N-1:0]        req_done;
  logic [LW-1:0]       req_data;
  logic                l2_valid;
  logic [AW-1:0]       l2_addr;
  logic                l2_done;
  logic [LW-1:0]       l2_data;
  logic                busy;
  logic [$clog2(N)-1:0] grant_id;
`ifdef GELATO_L2_ARB_TIMEOUT_EN
  logic                timeout_err;
`endif

  gelato_l2_arbiter #(
    .NUM_L1(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_done(req_done), .req_data(req_data),
    .l2_valid(l2_valid), .l2_addr(l2_addr),
    .l2_done(l2_done), .l2_data(l2_data),
    .busy(busy), .grant_id(grant_id)
`ifdef GELATO_L2_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who holds the L2 port, who is being answered, where fairness restarts.
  int            m_serving;
  int            m_grant;
  int            m_ptr;
  logic [N-1:0]  m_done;
  logic [LW-1:0] m_data;
  logic [AW-1:0] m_addr;

  bit  persist [N];
  int  rate;
  int  drop_pct;
  int  resp_cd;
  bit  prev_l2_valid;
  int  grant_log[$];

  task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW/32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic model_reset();
    m_serving = -1;
    m_grant   = 0;
    m_ptr     = 0;
    m_done    = '0;
    m_data    = '0;
    m_addr    = '0;
  endtask

  // Winner = valid requester with the smallest forward distance from the fairness pointer.
  task automatic model_step();
    int best;
    int bestd;
    if (m_done != 0) begin
      m_done = '0;
    end else if (m_serving >= 0) begin
      if (l2_done) begin
        m_data            = l2_data;
        m_done            = '0;
        m_done[m_serving] = 1'b1;
        m_ptr             = (m_serving + 1) % N;
        m_serving         = -1;
      end
    end else if (req_valid != 0) begin
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && ((i - m_ptr + N) % N) < bestd) begin
          best  = i;
          bestd = (i - m_ptr + N) % N;
        end
      end
      m_serving = best;
      m_grant   = best;
      m_addr    = req_addr[best*AW +: AW];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    check_val("l2_valid", LW'(l2_valid), LW'(m_serving >= 0));
    check_val("l2_addr",  LW'(l2_addr),  LW'(m_addr));
    check_val("grant_id", LW'(grant_id), LW'(m_grant));
    check_val("req_done", LW'(req_done), LW'(m_done));
    check_val("req_data", req_data, m_data);
    check_val("busy",     LW'(busy),     LW'((m_serving >= 0) || (m_done != 0)));
    if (l2_valid && !prev_l2_valid) grant_log.push_back(int'(grant_id));
    prev_l2_valid = l2_valid;
    if (req_done != 0)
      $display("txn done=%b grant=%0d addr=%h data=%h", req_done, grant_id, l2_addr, req_data[31:0]);
  endtask

  task automatic requester_step();
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_done[i]) begin
        if (persist[i]) req_addr[i*AW +: AW] = $urandom();
        else            req_valid[i] = 1'b0;
      end else if (!req_valid[i]) begin
        if ($urandom_range(99, 0) < rate) begin
          req_valid[i]         = 1'b1;
          req_addr[i*AW +: AW] = $urandom();
        end
      end else if (m_serving != i && m_done[i] == 1'b0 && $urandom_range(99, 0) < drop_pct) begin
        if ($urandom_range(1, 0) == 1) req_valid[i] = 1'b0;
        else                           req_addr[i*AW +: AW] = $urandom();
      end
    end
  endtask

  task automatic responder_step(input int lat_min, input int lat_max, input int spur_pct, input bit fixed);
    l2_done = 1'b0;
    if (l2_valid) begin
      if (resp_cd < 0) resp_cd = $urandom_range(lat_max, lat_min);
      if (resp_cd == 0) begin
        l2_done = 1'b1;
        l2_data = fixed ? {64{8'hA5}} : rand_line();
        resp_cd = -1;
      end else begin
        resp_cd--;
      end
    end else if ($urandom_range(99, 0) < spur_pct) begin
      l2_done = 1'b1;
      l2_data = rand_line();
    end
  endtask

  // Called at a falling edge; reset is raised between edges to exercise its asynchronous path.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_val("arst_l2_valid", LW'(l2_valid), '0);
    check_val("arst_busy",     LW'(busy),     '0);
    check_val("arst_grant",    LW'(grant_id), '0);
    check_val("arst_done",     LW'(req_done), '0);
    req_valid     = '0;
    l2_done       = 1'b0;
    resp_cd       = -1;
    prev_l2_valid = 1'b0;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_grants(input int n, input int bound);
    for (int c = 0; c < bound && grant_log.size() < n; c++) begin
      tick();
      requester_step();
      responder_step(0, 3, 0, 1'b0);
    end
  endtask

  task automatic check_order(input string tag, input int exp_q[$]);
    check_val({tag, "_count"}, LW'(grant_log.size()), LW'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (k < grant_log.size())
        check_val($sformatf("%s_g%0d", tag, k), LW'(grant_log[k]), LW'(exp_q[k]));
  endtask

  initial begin
    bit seen;
    int lat;
    req_valid = '0;
    req_addr  = '0;
    l2_done   = 1'b0;
    l2_data   = '0;
    resp_cd   = -1;
    rate      = 0;
    drop_pct  = 0;
    prev_l2_valid = 1'b0;
    for (int i = 0; i < N; i++) persist[i] = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single request with 3-cycle L2 latency.
    req_addr[1*AW +: AW] = 32'h1000;
    req_valid = 4'b0010;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (l2_valid) check_val("single_addr", LW'(l2_addr), LW'(32'h1000));
      if (req_done[1]) begin
        seen = 1'b1;
        check_val("single_data", req_data, {64{8'hA5}});
        check_val("single_grant", LW'(grant_id), LW'(1));
      end
      requester_step();
      responder_step(3, 3, 0, 1'b1);
    end
    check_val("single_seen", LW'(seen), LW'(1));
    tick();
    tick();
    check_val("single_idle", LW'(busy), '0);

    // All four contend, each re-requesting after its done.
    do_reset();
    for (int i = 0; i < N; i++) begin
      persist[i] = 1'b1;
      req_addr[i*AW +: AW] = $urandom();
    end
    req_valid = '1;
    grant_log.delete();
    run_grants(5, 200);
    check_order("contend", '{0, 1, 2, 3, 0});

    // Requesters 0 and 2 both always pending.
    do_reset();
    for (int i = 0; i < N; i++) persist[i] = (i == 0 || i == 2);
    req_valid = 4'b0101;
    grant_log.delete();
    run_grants(4, 200);
    check_order("fair", '{0, 2, 0, 2});

    // Spurious l2_done in IDLE, then zero-latency L2 answer.
    do_reset();
    for (int i = 0; i < N; i++) persist[i] = 1'b0;
    repeat (3) begin
      l2_done = 1'b1;
      l2_data = rand_line();
      tick();
      l2_done = 1'b0;
      check_val("spur_no_done", LW'(req_done), '0);
      tick();
    end
    req_addr[3*AW +: AW] = 32'h0000_2040;
    req_valid = 4'b1000;
    seen = 1'b0;
    lat  = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      lat++;
      if (req_done[3]) seen = 1'b1;
      requester_step();
      responder_step(0, 0, 0, 1'b0);
    end
    check_val("zero_seen", LW'(seen), LW'(1));
    check_val("zero_latency", LW'(lat), LW'(2));

    // Reset while requester 3 is being served; a late l2_done must be ignored.
    do_reset();
    req_addr[3*AW +: AW] = 32'h0000_3000;
    req_valid = 4'b1000;
    for (int c = 0; c < 10 && !l2_valid; c++) tick();
    tick();
    tick();
    check_val("mid_grant", LW'(grant_id), LW'(3));
    do_reset();
    l2_done = 1'b1;
    l2_data = rand_line();
    tick();
    l2_done = 1'b0;
    check_val("late_done_ignored", LW'(req_done), '0);
    req_addr[0] = 1'b0;
    req_valid = 4'b1001;
    grant_log.delete();
    run_grants(1, 50);
    check_order("post_rst", '{0});

`ifdef GELATO_L2_ARB_TIMEOUT_EN
    // Withhold l2_done past the watchdog limit.
    do_reset();
    check_val("to_init", LW'(timeout_err), '0);
    req_addr[2*AW +: AW] = 32'hCAFE_0040;
    req_valid = 4'b0100;
    tick();
    check_val("to_grant", LW'(l2_valid), LW'(1));
    for (int k = 1; k < TO; k++) begin
      tick();
      check_val("to_early", LW'(timeout_err), '0);
    end
    tick();
    check_val("to_set", LW'(timeout_err), LW'(1));
    l2_done = 1'b1;
    l2_data = rand_line();
    tick();
    l2_done = 1'b0;
    check_val("to_done", LW'(req_done), LW'(4'b0100));
    req_valid = '0;
    tick();
    check_val("to_sticky", LW'(timeout_err), LW'(1));
    do_reset();
    check_val("to_clear", LW'(timeout_err), '0);
`endif

    // Random traffic with drops, address churn, spurious L2 pulses and one reset.
    do_reset();
    for (int i = 0; i < N; i++) persist[i] = ($urandom_range(1, 0) == 1);
    rate     = 25;
    drop_pct = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      tick();
      requester_step();
      responder_step(0, 5, 6, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
